dec_n_scan: RTL

- Parametrised, registered N-to-2^N one-hot decoder.
- Adds two operating modes:
  - DIRECT: latches a select on a valid strobe.
  - SCAN: automatically steps the active output through a programmable range, dwelling a fixed number of cycles on each output.
- Intended use: digit/row strobing (multiplexed displays, keypad rows) and general address decode in the same designs as the existing 3-to-8 decoder.

---
 rtl/dec_n_scan.sv | 92 +++++++++
 1 files changed

// File: rtl/dec_n_scan.sv
// Registered N-to-2^N one-hot decoder with a DIRECT mode (select latched on a strobe)
// and a SCAN mode that walks the active output over 0..scan_max with a fixed dwell.
module dec_n_scan #(
    parameter int N          = 3,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    sel,
    input  logic            sel_valid,
    input  logic [N-1:0]    scan_max,
    output logic [2**N-1:0] y,
    output logic [N-1:0]    idx,
    output logic            y_valid,
    output logic            wrap
);

    localparam int M = 2**N;
    localparam logic [15:0] DwellLast = 16'(DWELL - 1);
    localparam logic [M-1:0] Inactive = {M{ACTIVE_LOW}};

    typedef enum logic [1:0] {StIdle, StDirect, StScan} state_t;

    state_t      state;
    logic [15:0] cnt;

    function automatic logic [M-1:0] decode(input logic [N-1:0] i);
        logic [M-1:0] v;
        v    = {M{ACTIVE_LOW}};
        v[i] = ~ACTIVE_LOW;
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            y       <= Inactive;
            idx     <= '0;
            y_valid <= 1'b0;
            wrap    <= 1'b0;
            cnt     <= '0;
        end else if (!en) begin
            // idx deliberately holds its last value while idle
            state   <= StIdle;
            y       <= Inactive;
            y_valid <= 1'b0;
            wrap    <= 1'b0;
            cnt     <= '0;
        end else if (!mode) begin
            state <= StDirect;
            wrap  <= 1'b0;
            cnt   <= '0;
            if (sel_valid) begin
                y       <= decode(sel);
                idx     <= sel;
                y_valid <= 1'b1;
            end else if (state != StDirect) begin
                y       <= Inactive;
                y_valid <= 1'b0;
            end
        end else begin
            state <= StScan;
            if (state != StScan) begin
                idx     <= '0;
                y       <= decode('0);
                y_valid <= 1'b1;
                cnt     <= '0;
                wrap    <= 1'b0;
            end else if (cnt == DwellLast) begin
                cnt <= '0;
                // >= covers scan_max lowered below idx mid-scan and keeps idx from overflowing
                if (idx >= scan_max) begin
                    idx  <= '0;
                    y    <= decode('0);
                    wrap <= 1'b1;
                end else begin
                    idx  <= idx + 1'b1;
                    y    <= decode(idx + 1'b1);
                    wrap <= 1'b0;
                end
                y_valid <= 1'b1;
            end else begin
                cnt  <= cnt + 16'd1;
                wrap <= 1'b0;
            end
        end
    end

endmodule
